// File: rtl/sync_fifo_flags.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : sync_fifo_flags
// Brief   : Single-clock FIFO with occupancy count, almost flags, sticky
//           overflow/underflow and selectable FWFT read mode.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_af_level = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] c_ae_level = (AW+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_pop_ok;
    logic w_push_ok;

    // Flags decode only the registered count, never same-cycle requests.
    assign full         = (r_count == c_depth);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= c_af_level);
    assign almost_empty = (r_count <= c_ae_level);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A pop on full frees a slot, so a simultaneous push still fits.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // A new error in the same cycle as clr_err keeps the flag set.
            r_overflow  <= (r_overflow  & ~clr_err) | (push & ~w_push_ok);
            r_underflow <= (r_underflow & ~clr_err) | (pop  & ~w_pop_ok);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown only while it is valid so nothing stale leaks out.
            assign data_out = empty ? '0 : r_mem[r_rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            logic                  r_rd_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_pop_ok;
                    if (w_pop_ok) begin
                        r_data_out <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign data_out = r_data_out;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_sync_fifo_flags
// Brief   : Directed self-checking bench for sync_fifo_flags (FWFT=0 and FWFT=1).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_sync_fifo_flags;

    logic       clk, rst, push, pop, clr_err;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic       vld0, full0, empty0, af0, ae0, ovf0, unf0;
    logic       vld1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
        .data_out(dout0), .rd_valid(vld0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
        .data_out(dout1), .rd_valid(vld1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; data_in = 8'(i);
            tick();
        end
        push = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cnt0 !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
        checks++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin failures++; $display("FAIL reset_flags got=%b exp=1010", {empty0, full0, ae0, af0}); end
        checks++; if ({ovf0, unf0, vld0} !== 3'b000) begin failures++; $display("FAIL reset_err_vld got=%b exp=000", {ovf0, unf0, vld0}); end
        checks++; if (dout0 !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout0); end
        checks++; if ({empty1, vld1} !== 2'b10) begin failures++; $display("FAIL reset_fwft got=%b exp=10", {empty1, vld1}); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; data_in = 8'(i);
            tick();
            checks++; if (cnt0 !== 5'(i + 1)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, cnt0, i + 1); end
            checks++; if (af0 !== (i + 1 >= 14)) begin failures++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, af0, (i + 1 >= 14)); end
            checks++; if (full0 !== (i + 1 == 16)) begin failures++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full0, (i + 1 == 16)); end
        end
        push = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pop = 1'b1;
            tick();
            checks++; if ({vld0, dout0} !== {1'b1, 8'(i)}) begin failures++; $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i, vld0, dout0, 8'(i)); end
            checks++; if (cnt0 !== 5'(15 - i)) begin failures++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, cnt0, 15 - i); end
            checks++; if (ae0 !== (15 - i <= 2)) begin failures++; $display("FAIL drain_ae i=%0d got=%b exp=%b", i, ae0, (15 - i <= 2)); end
        end
        pop = 1'b0;
        tick();
        checks++; if ({empty0, vld0, unf0} !== 3'b100) begin failures++; $display("FAIL drain_end got=%b exp=100", {empty0, vld0, unf0}); end
    endtask

    task automatic test_overflow();
        do_reset();
        fill16();
        push = 1'b1; data_in = 8'hAA;
        tick();
        push = 1'b0;
        checks++; if ({ovf0, full0, cnt0} !== {2'b11, 5'd16}) begin failures++; $display("FAIL ovf_set got=%b/%b/%0d exp=1/1/16", ovf0, full0, cnt0); end
        for (int i = 0; i < 16; i++) begin
            pop = 1'b1;
            tick();
            checks++; if (dout0 !== 8'(i)) begin failures++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, dout0, 8'(i)); end
        end
        pop = 1'b0;
        tick();
        checks++; if ({ovf0, empty0} !== 2'b11) begin failures++; $display("FAIL ovf_sticky got=%b exp=11", {ovf0, empty0}); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf0); end
    endtask

    task automatic test_underflow();
        do_reset();
        pop = 1'b1; push = 1'b1; data_in = 8'h55;
        tick();
        pop = 1'b0; push = 1'b0;
        checks++; if ({unf0, cnt0, vld0} !== {1'b1, 5'd1, 1'b0}) begin failures++; $display("FAIL unf_set got=%b/%0d/%b exp=1/1/0", unf0, cnt0, vld0); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        checks++; if ({vld0, dout0} !== {1'b1, 8'h55}) begin failures++; $display("FAIL unf_pop got=%b/%h exp=1/55", vld0, dout0); end
        pop = 1'b1; clr_err = 1'b1;
        tick();
        pop = 1'b0;
        checks++; if (unf0 !== 1'b1) begin failures++; $display("FAIL unf_set_wins got=%b exp=1", unf0); end
        tick();
        clr_err = 1'b0;
        checks++; if ({unf0, ovf0} !== 2'b00) begin failures++; $display("FAIL unf_clear got=%b exp=00", {unf0, ovf0}); end
    endtask

    task automatic test_simul_full();
        logic [7:0] exp;
        do_reset();
        fill16();
        push = 1'b1; pop = 1'b1; data_in = 8'h77;
        tick();
        push = 1'b0;
        checks++; if ({cnt0, ovf0, dout0} !== {5'd16, 1'b0, 8'h00}) begin failures++; $display("FAIL simul_full got=%0d/%b/%h exp=16/0/00", cnt0, ovf0, dout0); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'(i + 1) : 8'h77;
            tick();
            checks++; if (dout0 !== exp) begin failures++; $display("FAIL simul_drain i=%0d got=%h exp=%h", i, dout0, exp); end
        end
        pop = 1'b0;
        tick();
        checks++; if (empty0 !== 1'b1) begin failures++; $display("FAIL simul_empty got=%b exp=1", empty0); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] next;
        logic [7:0] exp;
        do_reset();
        next = 8'h00;
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; data_in = next; q.push_back(next); next++;
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            push = (i % 8 < 4) ? 1'b1 : 1'(i % 2);
            pop  = (i % 8 < 4) ? 1'(i % 2) : 1'b1;
            data_in = next;
            tick();
            if (pop) begin
                exp = q.pop_front();
                checks++; if ({vld0, dout0} !== {1'b1, exp}) begin failures++; $display("FAIL wrap_data i=%0d got=%b/%h exp=1/%h", i, vld0, dout0, exp); end
            end
            if (push) begin
                q.push_back(next); next++;
            end
            checks++; if (cnt0 !== 5'(q.size()) || cnt0 < 5'd3 || cnt0 > 5'd9) begin failures++; $display("FAIL wrap_count i=%0d got=%0d exp=%0d", i, cnt0, q.size()); end
        end
        push = 1'b0; pop = 1'b0;
        checks++; if ({ovf0, unf0, full0, empty0} !== 4'b0000) begin failures++; $display("FAIL wrap_flags got=%b exp=0000", {ovf0, unf0, full0, empty0}); end
    endtask

    task automatic test_fwft_reset();
        do_reset();
        push = 1'b1; data_in = 8'h12;
        tick();
        push = 1'b0;
        checks++; if ({vld1, dout1} !== {1'b1, 8'h12}) begin failures++; $display("FAIL fwft_head got=%b/%h exp=1/12", vld1, dout1); end
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; data_in = 8'(8'h13 + i);
            tick();
        end
        push = 1'b0;
        checks++; if ({cnt1, dout1} !== {5'd5, 8'h12}) begin failures++; $display("FAIL fwft_hold got=%0d/%h exp=5/12", cnt1, dout1); end
        rst = 1'b1; push = 1'b1; pop = 1'b1; data_in = 8'hEE;
        tick();
        rst = 1'b0; push = 1'b0; pop = 1'b0;
        checks++; if ({cnt1, empty1, vld1} !== {5'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL fwft_reset got=%0d/%b/%b exp=0/1/0", cnt1, empty1, vld1); end
        push = 1'b1; data_in = 8'h34;
        tick();
        data_in = 8'h35;
        tick();
        push = 1'b0;
        checks++; if ({vld1, dout1} !== {1'b1, 8'h34}) begin failures++; $display("FAIL fwft_new got=%b/%h exp=1/34", vld1, dout1); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        checks++; if ({vld1, dout1, cnt1} !== {1'b1, 8'h35, 5'd1}) begin failures++; $display("FAIL fwft_pop got=%b/%h/%0d exp=1/35/1", vld1, dout1, cnt1); end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = 8'h00;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_simul_full();
        test_wrap();
        test_fwft_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
